// File: rtl/aes_pkg.sv
// aes_pkg: shared state type and constants for aes_result_ser (TRAIL state exists only with AES_SER_CRC_EN)
package aes_pkg;
  localparam int AES_BLK_BYTES = 16;
  localparam logic [7:0] CRC8_POLY = 8'h07;
`ifdef AES_SER_CRC_EN
  typedef enum logic [1:0] {IDLE, SEND, TRAIL} ser_state_e;
`else
  typedef enum logic [1:0] {IDLE, SEND} ser_state_e;
`endif
endpackage

// File: rtl/aes_crc8.sv
// aes_crc8: combinational CRC-8 (poly 0x07, MSB-first) update of one data byte
module aes_crc8
  import aes_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);
  logic [7:0] c;
  // shift the combined byte through the polynomial one bit at a time
  always_comb begin
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) c = c[7] ? (c << 1) ^ CRC8_POLY : c << 1;
    crc_o = c;
  end
endmodule

// File: rtl/aes_result_ser.sv
// aes_result_ser: serialises a 128-bit cipher result into a valid/ready byte stream; AES_SER_CRC_EN appends a CRC-8 trailer byte
module aes_result_ser
  import aes_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         done,
  input  logic [127:0] text_out,
  output logic [7:0]   result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_ovr
);
  ser_state_e state_q, state_d;
  logic [127:0] hold_q, hold_d;
  logic [3:0] idx_q, idx_d;
  logic done_q, ovr_q, ovr_d, cap, xfer, last;
  logic [7:0] byte_sel;
  assign cap = done & ~done_q;
  assign xfer = result_valid & result_ready;
  assign last = idx_q == 4'(AES_BLK_BYTES - 1);
  assign byte_sel = hold_q[(MSB_FIRST ? {~idx_q, 3'b000} : {idx_q, 3'b000}) +: 8];
  assign result_valid = state_q != IDLE;
  assign busy = result_valid;
  assign overrun = ovr_q;
`ifdef AES_SER_CRC_EN
  logic [7:0] crc_q, crc_d, crc_nxt;
  aes_crc8 u_crc (
    .crc_i (crc_q),
    .data_i(byte_sel),
    .crc_o (crc_nxt)
  );
  assign result = state_q == SEND ? byte_sel : state_q == TRAIL ? crc_q : 8'h00;
`else
  assign result = state_q == SEND ? byte_sel : 8'h00;
`endif
  // next state: capture only from IDLE, advance one byte per transfer, a capture while busy only flags overrun
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    idx_d = idx_q;
    ovr_d = (cap & busy) | (ovr_q & ~clr_ovr);
`ifdef AES_SER_CRC_EN
    crc_d = crc_q;
`endif
    if (state_q == IDLE && cap) begin
      state_d = SEND;
      hold_d = text_out;
      idx_d = '0;
`ifdef AES_SER_CRC_EN
      crc_d = '0;
`endif
    end
    if (state_q == SEND && xfer) begin
      idx_d = idx_q + 4'd1;
`ifdef AES_SER_CRC_EN
      crc_d = crc_nxt;
      state_d = last ? TRAIL : SEND;
`else
      state_d = last ? IDLE : SEND;
`endif
    end
`ifdef AES_SER_CRC_EN
    if (state_q == TRAIL && xfer) state_d = IDLE;
`endif
  end
  // state, holding register, index, edge detector and sticky overrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q <= '0;
      idx_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      idx_q <= idx_d;
      done_q <= done;
      ovr_q <= ovr_d;
    end
`ifdef AES_SER_CRC_EN
  // running CRC over the bytes transferred so far in this block
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc_q <= '0;
    else crc_q <= crc_d;
`endif
endmodule

// File: tb/tb_aes_result_ser.sv
// tb_aes_result_ser: randomized bench comparing MSB_FIRST=1 and MSB_FIRST=0 instances against a byte-queue model
module tb_aes_result_ser;
  localparam logic [127:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_SER_CRC_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  logic clk = 1'b0;
  logic rst_n, done, result_ready, clr_ovr;
  logic [127:0] text_out, blk;
  logic [7:0] res0, res1;
  logic v0, v1, b0, b1, o0, o1;
  int n_chk = 0, n_fail = 0;
  logic [7:0] q0[$], q1[$];
  logic m_ovr, m_done_prev, was_busy, m_cap;
  logic [3:0] pat = 4'b1001;
  always #5 clk = ~clk;
  aes_result_ser #(.MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .done(done), .text_out(text_out), .result(res0),
    .result_valid(v0), .result_ready(result_ready), .busy(b0), .overrun(o0), .clr_ovr(clr_ovr)
  );
  aes_result_ser #(.MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .done(done), .text_out(text_out), .result(res1),
    .result_valid(v1), .result_ready(result_ready), .busy(b1), .overrun(o1), .clr_ovr(clr_ovr)
  );
  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1, message bits in transmit order
  function automatic logic [7:0] crc_ref(input logic [127:0] m);
    logic [135:0] r;
    r = {m, 8'h00};
    for (int i = 135; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction
  function automatic logic [127:0] byte_reverse(input logic [127:0] x);
    logic [127:0] y, s;
    y = '0;
    s = x;
    for (int k = 0; k < 16; k++) begin
      y = {y[119:0], s[7:0]};
      s = s >> 8;
    end
    return y;
  endfunction
  function automatic logic [7:0] head0();
    return q0.size() != 0 ? q0[0] : 8'h00;
  endfunction
  function automatic logic [7:0] head1();
    return q1.size() != 0 ? q1[0] : 8'h00;
  endfunction
  // behavioural model: a block is a list of bytes waiting to go out; new blocks only accepted when the list is empty
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_ovr = 1'b0;
      m_done_prev = 1'b0;
    end else begin
      was_busy = q0.size() != 0;
      m_cap = done && !m_done_prev;
      if (was_busy && result_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (m_cap && was_busy) m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
      if (m_cap && !was_busy) begin
        for (int k = 0; k < 16; k++) begin
          q0.push_back(text_out[127 - 8 * k -: 8]);
          q1.push_back(text_out[8 * k +: 8]);
        end
`ifdef AES_SER_CRC_EN
        q0.push_back(crc_ref(text_out));
        q1.push_back(crc_ref(byte_reverse(text_out)));
`endif
      end
      m_done_prev = done;
    end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_all();
    check("valid_msb", 32'(v0), 32'(q0.size() != 0));
    check("result_msb", 32'(res0), 32'(head0()));
    check("busy_msb", 32'(b0), 32'(q0.size() != 0));
    check("overrun_msb", 32'(o0), 32'(m_ovr));
    check("valid_lsb", 32'(v1), 32'(q1.size() != 0));
    check("result_lsb", 32'(res1), 32'(head1()));
    check("busy_lsb", 32'(b1), 32'(q1.size() != 0));
    check("overrun_lsb", 32'(o1), 32'(m_ovr));
  endtask
  task automatic tick();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
  endtask
  task automatic send_done(input logic [127:0] t);
    text_out = t;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    done = 1'b0;
    result_ready = 1'b1;
    clr_ovr = 1'b0;
    text_out = '0;
    check("crc_pin_01", 32'(crc_ref(128'h01)), 32'h07);
    check("crc_pin_80", 32'(crc_ref(128'h80)), 32'h89);
    check("byterev_pin", 32'(byte_reverse(FIPS) >> 120), 32'h5a);
    repeat (3) tick();
    check("reset_result", 32'(res0), 32'h00);
    check("reset_valid", 32'(v0), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();
    // known-answer block, ready held high
    send_done(FIPS);
    check("fips_first_msb", 32'(res0), 32'h69);
    check("fips_first_lsb", 32'(res1), 32'h5a);
    check("fips_first_valid", 32'(v0), 32'h1);
    repeat (15) tick();
    check("fips_last_msb", 32'(res0), 32'h5a);
    check("fips_last_lsb", 32'(res1), 32'h69);
`ifdef AES_SER_CRC_EN
    tick();
    check("fips_crc_msb", 32'(res0), 32'(crc_ref(FIPS)));
    check("fips_crc_lsb", 32'(res1), 32'(crc_ref(byte_reverse(FIPS))));
`endif
    tick();
    check("fips_busy_after", 32'(b0), 32'h0);
    repeat (2) tick();
    // stalling consumer: ready 1,0,0,1 repeating
    send_done({$urandom, $urandom, $urandom, $urandom});
    for (int c = 0; c < 80; c++) begin
      result_ready = pat[c % 4];
      tick();
    end
    result_ready = 1'b1;
    repeat (NB) tick();
    // overrun: new edge at byte 5 and on the final-transfer cycle
    send_done(FIPS);
    repeat (5) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (NB - 7) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("ovr_set", 32'(o0), 32'h1);
    check("ovr_idle", 32'(b0), 32'h0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", 32'(o0), 32'h0);
    // clear and set on the same cycle: set wins
    send_done({$urandom, $urandom, $urandom, $urandom});
    repeat (3) tick();
    done = 1'b1;
    clr_ovr = 1'b1;
    tick();
    done = 1'b0;
    clr_ovr = 1'b0;
    check("ovr_set_wins", 32'(o0), 32'h1);
    repeat (NB) tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    // reset mid-block after byte 7
    send_done({$urandom, $urandom, $urandom, $urandom});
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("rst_result", 32'(res0), 32'h00);
    check("rst_valid", 32'(v0), 32'h0);
    check("rst_busy", 32'(b0), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    blk = {$urandom, $urandom, $urandom, $urandom};
    send_done(blk);
    check("post_rst_first", 32'(res0), 32'(blk >> 120));
    repeat (NB + 1) tick();
    // done held high across reset release counts as an edge
    rst_n = 1'b0;
    #1;
    done = 1'b1;
    text_out = FIPS;
    tick();
    rst_n = 1'b1;
    tick();
    check("done_high_release", 32'(v0), 32'h1);
    done = 1'b0;
    repeat (NB + 1) tick();
`ifdef AES_SER_CRC_EN
    // all-zero block: data and trailer all zero
    send_done('0);
    repeat (16) tick();
    check("zero_crc_valid", 32'(v0), 32'h1);
    check("zero_crc", 32'(res0), 32'h00);
    repeat (2) tick();
`endif
    // random traffic
    for (int c = 0; c < 600; c++) begin
      result_ready = $urandom_range(0, 3) != 0;
      clr_ovr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 5) == 0) begin
        done = ~done;
        text_out = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
